fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch stage plus IF/ID pipeline register, directly upstream of control_unit.
//   Holds the PC and drives the combinational instruction-memory address.
//   Registers the fetched word and splits it into OpcodeD/FuncD/RdD for decode.
//   Handles stall, flush and branch redirect, and freezes fetch when decode reports Stuck (halt).
// PARAMETERS
//   ADDR_WIDTH  32   PC / address width
//   INSTR_WIDTH 32   instruction width
//   RESET_PC    0    PC value loaded on reset
//   PC_STEP     4    byte increment per sequential fetch
// PORTS
//   clk            in   1            system clock, rising edge
//   rst_n          in   1            asynchronous active-low reset
//   InstrF         in   INSTR_WIDTH  instruction memory read data for PCF (combinational ROM)
//   PCF            out  ADDR_WIDTH   fetch address to instruction memory
//   StallF         in   1            hazard unit: hold PCF
//   StallD         in   1            hazard unit: hold IF/ID register
//   FlushD         in   1            hazard unit: bubble IF/ID register
//   BranchTakenE   in   1            taken branch resolved in execute
//   BranchTargetE  in   ADDR_WIDTH   redirect target
//   Stuck          in   1            from control_unit: instruction in D is a halt
//   InstrD         out  INSTR_WIDTH  registered instruction
//   OpcodeD        out  6            InstrD[31:26]
//   RdD            out  5            InstrD[25:21]
//   FuncD          out  3            InstrD[2:0]
//   PCPlus4D       out  ADDR_WIDTH   PC of InstrD + PC_STEP
//   ValidD         out  1            InstrD is a real instruction (0 = bubble)
//   Halted         out  1            fetch frozen by halt
//   FetchCount     out  32           valid instructions loaded into IF/ID
// BEHAVIOUR
//   Reset (async, immediate in any state): PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0,
//     Halted=0, FetchCount=0, state=RUN.
//   OpcodeD/RdD/FuncD are pure slices of InstrD (no extra latency).
//   Latency: InstrF presented with PCF in cycle N appears on InstrD in cycle N+1.
//   FSM states:
//     RUN  - normal fetch.
//     HALT - terminal; left only via rst_n.
//   RUN->HALT on an edge where all hold: ValidD=1, Stuck=1, BranchTakenE=0, FlushD=0
//     (evaluated even while StallD=1).
//   A taken branch in the same cycle as Stuck wins: the halt is wrong-path, so the FSM stays RUN.
//   PC next-value priority:
//     1. HALT or halting transition -> hold PCF
//     2. BranchTakenE -> BranchTargetE
//     3. StallF -> hold PCF
//     4. otherwise -> PCF+PC_STEP (wraps mod 2^ADDR_WIDTH)
//   IF/ID next-value priority:
//     1. HALT or halting transition -> bubble
//     2. BranchTakenE or FlushD -> bubble
//     3. StallD -> hold all D outputs
//     4. otherwise -> load InstrF, PCF+PC_STEP, ValidD=1
//   Bubble means InstrD=0, PCPlus4D=0, ValidD=0.
//   Halted=1 from the edge that enters HALT onward.
//   FetchCount increments by 1 only in the "load" case; wraps 2^32-1 -> 0.
//   Legal hazard combos: StallF+StallD together; StallF+FlushD (load-use bubble).
//     StallF=1 with StallD=0 and FlushD=0 is illegal; the bench asserts it never occurs.
//   BranchTakenE overrides StallF/StallD (redirect is never lost).
// TESTING
//   1. Reset release, InstrF=0x00000820 each cycle:
//      -> PCF 0,4,8..., ValidD=1 from 2nd edge, OpcodeD=000000, RdD=00000, FetchCount=1,2,3.
//   2. StallF=StallD=1 for 3 cycles at PCF=0x10:
//      -> PCF stays 0x10, InstrD/PCPlus4D held, FetchCount unchanged; resumes at 0x14.
//   3. BranchTakenE=1, BranchTargetE=0x40, StallD=1:
//      -> next PCF=0x40, ValidD=0 next cycle, InstrD=0.
//   4. Halt word in D (Stuck=1, ValidD=1):
//      -> Halted=1 next edge, PCF frozen, ValidD=0 thereafter; BranchTakenE later ignored.
//   5. Stuck=1 and BranchTakenE=1 (target 0x80) same cycle:
//      -> Halted=0, PCF=0x80, D bubbled.
//   6. rst_n low mid-stall and mid-HALT:
//      -> all outputs to reset values without a clock edge; PCF=RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage signal bundle.
//   master - the fetch stage: drives PCF and the IF/ID outputs,
//            and takes InstrF plus the hazard/decode inputs.
//   slave  - the environment: instruction ROM, hazard unit and control_unit.
interface fetch_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] InstrF;
  logic [ADDR_WIDTH-1:0]  PCF;
  logic                   StallF;
  logic                   StallD;
  logic                   FlushD;
  logic                   BranchTakenE;
  logic [ADDR_WIDTH-1:0]  BranchTargetE;
  logic                   Stuck;
  logic [INSTR_WIDTH-1:0] InstrD;
  logic [5:0]             OpcodeD;
  logic [4:0]             RdD;
  logic [2:0]             FuncD;
  logic [ADDR_WIDTH-1:0]  PCPlus4D;
  logic                   ValidD;
  logic                   Halted;
  logic [31:0]            FetchCount;

  modport master (
    input  InstrF, StallF, StallD, FlushD, BranchTakenE, BranchTargetE, Stuck,
    output PCF, InstrD, OpcodeD, RdD, FuncD, PCPlus4D, ValidD, Halted, FetchCount
  );

  modport slave (
    output InstrF, StallF, StallD, FlushD, BranchTakenE, BranchTargetE, Stuck,
    input  PCF, InstrD, OpcodeD, RdD, FuncD, PCPlus4D, ValidD, Halted, FetchCount
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction fetch and IF/ID pipeline register.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fetch_if.master
//                in : InstrF, StallF, StallD, FlushD, BranchTakenE, BranchTargetE, Stuck
//                out: PCF, InstrD, OpcodeD, RdD, FuncD, PCPlus4D, ValidD, Halted, FetchCount
// A halt reported by decode (Stuck on a valid D instruction) freezes fetch
// for good; only rst_n leaves the HALT state.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4)
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pcp4_q, pcp4_d;
  logic                   valid_q, valid_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   halt_go, freeze, halted, load;
  logic [ADDR_WIDTH-1:0]  pc_seq;

  // A taken branch or flush marks the D halt as wrong-path, so it must not halt.
  assign halt_go = (state_q == S_RUN) & valid_q & bus.Stuck
                 & ~bus.BranchTakenE & ~bus.FlushD;
  assign pc_seq  = pc_q + PC_STEP;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN && halt_go) state_d = S_HALT;
  end

  // FSM: outputs
  always_comb begin
    halted = (state_q == S_HALT);
    freeze = (state_q == S_HALT) | halt_go;
  end

  // PC and IF/ID next values
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    load    = 1'b0;
    if (freeze) begin
      pc_d = pc_q;
    end else if (bus.BranchTakenE) begin
      pc_d = bus.BranchTargetE;
    end else if (!bus.StallF) begin
      pc_d = pc_seq;
    end
    if (freeze || bus.BranchTakenE || bus.FlushD) begin
      instr_d = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
    end else if (!bus.StallD) begin
      instr_d = bus.InstrF;
      pcp4_d  = pc_seq;
      valid_d = 1'b1;
      load    = 1'b1;
    end
    cnt_d = cnt_q + 32'(load);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCF        = pc_q;
  assign bus.InstrD     = instr_q;
  assign bus.OpcodeD    = instr_q[31:26];
  assign bus.RdD        = instr_q[25:21];
  assign bus.FuncD      = instr_q[2:0];
  assign bus.PCPlus4D   = pcp4_q;
  assign bus.ValidD     = valid_q;
  assign bus.Halted     = halted;
  assign bus.FetchCount = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Instruction ROM: either a fixed word or a scrambled function of the address.
  bit          const_mode;
  logic [31:0] const_word;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0C3F;
  endfunction
  assign bus.InstrF = const_mode ? const_word : rom(bus.PCF);

  int errors = 0;
  int checks = 0;

  // Reference model, in terms of the architectural state only.
  logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
  bit          m_valid, m_halt;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pcp4 = 0; m_cnt = 0; m_valid = 0; m_halt = 0;
  endtask

  task automatic model_edge();
    logic [31:0] fetched;
    bit go;
    fetched = const_mode ? const_word : rom(m_pc);
    go = !m_halt && m_valid && bus.Stuck && !bus.BranchTakenE && !bus.FlushD;
    if (m_halt || go) begin
      m_instr = 0; m_pcp4 = 0; m_valid = 0;
      m_halt  = 1;
    end else begin
      if (bus.BranchTakenE || bus.FlushD) begin
        m_instr = 0; m_pcp4 = 0; m_valid = 0;
      end else if (!bus.StallD) begin
        m_instr = fetched; m_pcp4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
      end
      if (bus.BranchTakenE)  m_pc = bus.BranchTargetE;
      else if (!bus.StallF)  m_pc = m_pc + 4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PCF"},        bus.PCF,              m_pc);
    chk({tag, ".InstrD"},     bus.InstrD,           m_instr);
    chk({tag, ".OpcodeD"},    32'(bus.OpcodeD),     32'(m_instr[31:26]));
    chk({tag, ".RdD"},        32'(bus.RdD),         32'(m_instr[25:21]));
    chk({tag, ".FuncD"},      32'(bus.FuncD),       32'(m_instr[2:0]));
    chk({tag, ".PCPlus4D"},   bus.PCPlus4D,         m_pcp4);
    chk({tag, ".ValidD"},     32'(bus.ValidD),      32'(m_valid));
    chk({tag, ".Halted"},     32'(bus.Halted),      32'(m_halt));
    chk({tag, ".FetchCount"}, bus.FetchCount,       m_cnt);
  endtask

  // Advance one clock edge; called at posedge+1 with inputs already set.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit sf, input bit sd, input bit fd, input bit br,
                        input logic [31:0] tgt, input bit st);
    bus.StallF = sf; bus.StallD = sd; bus.FlushD = fd;
    bus.BranchTakenE = br; bus.BranchTargetE = tgt; bus.Stuck = st;
  endtask

  // Asynchronous reset between edges, checked before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    set_in(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_edge();
    check_all({tag, "_rel"});
  endtask

  task automatic rand_in(input bit allow_stuck);
    int r;
    r = int'($urandom % 8);
    bus.StallF = (r == 4 || r == 5);
    bus.StallD = (r == 4);
    bus.FlushD = (r == 5 || r == 6);
    bus.BranchTakenE = ($urandom % 8 == 0);
    bus.BranchTargetE = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    bus.Stuck = allow_stuck && m_valid && ($urandom % 12 == 0);
  endtask

  // The hazard unit must never stall F without stalling or flushing D.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.StallF && !bus.StallD && !bus.FlushD)) else begin
        errors++;
        $error("FAIL illegal_hazard observed=StallF_only expected=legal_combo");
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    const_mode = 1'b1;
    const_word = 32'h0000_0820;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #3 check_all("reset");
    #4 rst_n = 1'b1;

    // 1: sequential fetch of a constant word
    for (int i = 0; i < 4; i++) step("t1");
    chk("t1_pc_abs",  bus.PCF,        32'h10);
    chk("t1_cnt_abs", bus.FetchCount, 32'd4);
    chk("t1_op_abs",  32'(bus.OpcodeD), 32'd0);

    // 2: stall F and D together at 0x10
    const_mode = 1'b0;
    set_in(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t2_stall");
    chk("t2_pc_held", bus.PCF, 32'h10);
    set_in(0, 0, 0, 0, 0, 0);
    step("t2_resume");
    chk("t2_pc_resume", bus.PCF, 32'h14);

    // 3: branch overrides StallD
    set_in(0, 1, 0, 1, 32'h40, 0);
    step("t3_br");
    chk("t3_pc_abs",    bus.PCF,           32'h40);
    chk("t3_valid_abs", 32'(bus.ValidD),   32'd0);
    set_in(0, 0, 0, 0, 0, 0);
    step("t3_after");

    // random legal hazards, no halts; includes PC wrap via 0xFFFFFFF8 targets
    for (int i = 0; i < 300; i++) begin
      rand_in(0);
      step("rnd_a");
    end

    // 4: halt in D
    set_in(0, 0, 0, 0, 0, 0);
    step("t4_pre");
    set_in(0, 0, 0, 0, 0, 1);
    step("t4_halt");
    chk("t4_halted_abs", 32'(bus.Halted), 32'd1);
    set_in(0, 0, 0, 1, 32'h200, 0);
    step("t4_br_ignored");
    set_in(0, 0, 0, 0, 0, 0);
    step("t4_frozen");

    // 6a: reset mid-HALT
    async_reset("t6_halt_rst");

    // 5: branch wins over Stuck
    set_in(0, 0, 0, 0, 0, 0);
    step("t5_pre");
    set_in(0, 0, 0, 1, 32'h80, 1);
    step("t5_br_stuck");
    chk("t5_pc_abs",     bus.PCF,          32'h80);
    chk("t5_halted_abs", 32'(bus.Halted),  32'd0);
    set_in(0, 0, 0, 0, 0, 0);
    step("t5_after");

    // 6b: reset mid-stall
    set_in(1, 1, 0, 0, 0, 0);
    step("t6_stall");
    async_reset("t6_stall_rst");

    // random with occasional halts, periodic resets to leave HALT
    for (int i = 0; i < 400; i++) begin
      rand_in(1);
      step("rnd_b");
      if (i % 60 == 59) async_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
